// File: rtl/mem_bus_arbiter_if.sv
// Memory-side bus of mem_bus_arbiter: one single-port, variable-latency
// beat interface. The arbiter is the master; the external memory is the slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req;
    logic [DATA_WIDTH/8-1:0] mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises the core's data (RAM) and fetch (ROM) requests onto one memory
// bus. The data beat always goes first, the pipeline is stalled while beats
// are outstanding, and each beat is supervised by a timeout that raises a
// sticky bus_error.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    halt,
    output logic                    core_stall,
    input  logic                    rom_en,
    input  logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic [DATA_WIDTH-1:0]   rom_read_data,
    input  logic                    ram_en,
    input  logic [DATA_WIDTH/8-1:0] ram_write_en,
    input  logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   ram_write_data,
    output logic [DATA_WIDTH-1:0]   ram_read_data,
    mem_bus_arbiter_if.master       mem,
    output logic                    bus_error
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_NEED  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_NEED > 8) ? CNT_NEED : 8;
    // Last wait cycle of a beat: if ready is still low here the beat aborts.
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    pend_fetch;
    logic [ADDR_WIDTH-1:0]   pend_rom_addr;
    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic                    accept;
    logic                    in_beat;
    logic                    beat_done;
    logic                    beat_abort;
    logic                    beat_end;
    logic                    req_d;
    logic [BE_WIDTH-1:0]     we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;

    assign accept     = (state == IDLE) && !halt && (ram_en || rom_en);
    assign in_beat    = ((state == DATA) || (state == FETCH)) && mem.mem_req;
    assign beat_done  = in_beat && mem.mem_ready;
    // Ready on the last wait cycle wins over the timeout.
    assign beat_abort = in_beat && !mem.mem_ready && (wait_cnt == LAST_WAIT);
    assign beat_end   = beat_done || beat_abort;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: data beat before fetch beat, one DONE cycle per core cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!halt && ram_en) begin
                    next_state = DATA;
                end else if (!halt && rom_en) begin
                    next_state = FETCH;
                end
            end
            DATA: begin
                if (beat_end) begin
                    next_state = pend_fetch ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (beat_end) begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: pipeline stall and the next value of the registered bus fields.
    always_comb begin
        core_stall = rst || halt || ((state == IDLE) && (rom_en || ram_en)) ||
                     (state == DATA) || (state == FETCH);
        req_d   = 1'b0;
        we_d    = '0;
        addr_d  = mem.mem_addr;
        wdata_d = mem.mem_wdata;
        case (next_state)
            DATA: begin
                req_d = 1'b1;
                if (state == IDLE) begin
                    we_d    = ram_write_en;
                    addr_d  = ram_addr;
                    wdata_d = ram_write_data;
                end else begin
                    we_d = mem.mem_we;
                end
            end
            FETCH: begin
                req_d = 1'b1;
                if (state == IDLE) begin
                    addr_d = rom_addr;
                end else if (state == DATA) begin
                    addr_d = pend_rom_addr;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered bus outputs; they double as the latch for the RAM request fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_req   <= req_d;
            mem.mem_we    <= we_d;
            mem.mem_addr  <= addr_d;
            mem.mem_wdata <= wdata_d;
        end
    end

    // Latch the fetch request on acceptance so it survives the data beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_fetch    <= 1'b0;
            pend_rom_addr <= '0;
        end else if (accept) begin
            pend_fetch    <= rom_en;
            pend_rom_addr <= rom_addr;
        end
    end

    // Per-beat wait counter: counts not-ready cycles, restarts at every beat boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!in_beat || beat_end) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Holding registers and sticky error; an aborted read leaves zero behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_read_data <= '0;
            ram_read_data <= '0;
            bus_error     <= 1'b0;
        end else begin
            if (beat_abort) begin
                bus_error <= 1'b1;
            end
            if ((state == DATA) && (mem.mem_we == '0)) begin
                if (beat_done) begin
                    ram_read_data <= mem.mem_rdata;
                end else if (beat_abort) begin
                    ram_read_data <= '0;
                end
            end
            if (state == FETCH) begin
                if (beat_done) begin
                    rom_read_data <= mem.mem_rdata;
                end else if (beat_abort) begin
                    rom_read_data <= '0;
                end
            end
        end
    end

endmodule
